// File: rtl/datapath_pipe_if.sv
// Control-word and result bundle between the sequencer and datapath_pipe.
// The sequencer takes the master side and the datapath takes the slave side.
interface datapath_pipe_if #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 8
);
  localparam int unsigned AW = $clog2(R);

  logic          ctrl_valid;
  logic [3:0]    fs;
  logic [AW-1:0] a_sel;
  logic [AW-1:0] b_sel;
  logic [AW-1:0] d_sel;
  logic          mb_s;
  logic          md_s;
  logic          wr_en;
  logic [N-1:0]  data_in;
  logic [N-1:0]  const_in;
  logic [N-1:0]  data_out;
  logic [N-1:0]  adrs_out;
  logic          out_valid;
  logic [3:0]    state_flags;

  modport master (
    output ctrl_valid, fs, a_sel, b_sel, d_sel, mb_s, md_s, wr_en, data_in, const_in,
    input  data_out, adrs_out, out_valid, state_flags
  );

  modport slave (
    input  ctrl_valid, fs, a_sel, b_sel, d_sel, mb_s, md_s, wr_en, data_in, const_in,
    output data_out, adrs_out, out_valid, state_flags
  );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage (RD/EX) register-file datapath with a 16-function ALU, Z/N/C/V flags
// and an EX-to-RD bypass so dependent control words issue back to back.
module datapath_pipe #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 8
) (
  input logic            clk,
  input logic            rst,
  datapath_pipe_if.slave bus
);
  localparam int unsigned AW = $clog2(R);
  localparam int unsigned NW = N + 1;

  logic [N-1:0]  rf [R];

  logic          ex_valid;
  logic [3:0]    ex_fs;
  logic [AW-1:0] ex_d;
  logic          ex_md;
  logic          ex_wr;
  logic [N-1:0]  ex_a;
  logic [N-1:0]  ex_b;
  logic [N-1:0]  ex_din;
  logic [3:0]    flags_q;

  logic [N-1:0]  y_c;
  logic          cin_c;
  logic [N:0]    sum_c;
  logic [N-1:0]  f_c;
  logic          c_c;
  logic          v_c;
  logic [N-1:0]  wb_c;
  logic          we_c;
  logic [N-1:0]  rd_a_c;
  logic [N-1:0]  rd_b_c;

  // Adder operand selection for the arithmetic group (fs 0-7)
  always_comb begin
    y_c   = '0;
    cin_c = 1'b0;
    case (ex_fs[2:0])
      3'd1: cin_c = 1'b1;
      3'd2: y_c = ex_b;
      3'd3: begin y_c = ex_b;  cin_c = 1'b1; end
      3'd4: y_c = ~ex_b;
      3'd5: begin y_c = ~ex_b; cin_c = 1'b1; end
      3'd6: y_c = '1;
      default: ;
    endcase
    sum_c = {1'b0, ex_a} + {1'b0, y_c} + NW'(cin_c);
  end

  // Function unit result and carry/overflow
  always_comb begin
    f_c = sum_c[N-1:0];
    c_c = 1'b0;
    v_c = 1'b0;
    case (ex_fs)
      4'd0, 4'd7: f_c = ex_a;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        c_c = sum_c[N];
        v_c = (ex_a[N-1] == y_c[N-1]) && (sum_c[N-1] != ex_a[N-1]);
      end
      4'd8:  f_c = ex_a & ex_b;
      4'd9:  f_c = ex_a | ex_b;
      4'd10: f_c = ex_a ^ ex_b;
      4'd11: f_c = ~ex_a;
      4'd13: begin f_c = {1'b0, ex_b[N-1:1]}; c_c = ex_b[0];   end
      4'd14: begin f_c = {ex_b[N-2:0], 1'b0}; c_c = ex_b[N-1]; end
      default: f_c = ex_b;
    endcase
  end

  // Write-back value doubles as the bypass source for the RD stage
  always_comb begin
    wb_c   = ex_md ? ex_din : f_c;
    we_c   = ex_valid && ex_wr;
    rd_a_c = (we_c && (ex_d == bus.a_sel)) ? wb_c : rf[bus.a_sel];
    if (bus.mb_s)
      rd_b_c = bus.const_in;
    else
      rd_b_c = (we_c && (ex_d == bus.b_sel)) ? wb_c : rf[bus.b_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(R); i++) rf[i] <= '0;
      ex_valid <= 1'b0;
      ex_fs    <= '0;
      ex_d     <= '0;
      ex_md    <= 1'b0;
      ex_wr    <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_din   <= '0;
      flags_q  <= '0;
    end else begin
      ex_valid <= bus.ctrl_valid;
      // Operand registers hold across bubbles so data_out/adrs_out keep their value
      if (bus.ctrl_valid) begin
        ex_fs  <= bus.fs;
        ex_d   <= bus.d_sel;
        ex_md  <= bus.md_s;
        ex_wr  <= bus.wr_en;
        ex_a   <= rd_a_c;
        ex_b   <= rd_b_c;
        ex_din <= bus.data_in;
      end
      if (we_c) rf[ex_d] <= wb_c;
      if (ex_valid && !ex_md) flags_q <= {f_c == '0, f_c[N-1], c_c, v_c};
    end
  end

  assign bus.data_out    = ex_b;
  assign bus.adrs_out    = ex_a;
  assign bus.out_valid   = ex_valid;
  assign bus.state_flags = flags_q;
endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random words
// checked against an architectural (one-word-at-a-time) reference model.
module tb_datapath_pipe;
  localparam int unsigned N  = 8;
  localparam int unsigned R  = 8;
  localparam int unsigned AW = $clog2(R);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  datapath_pipe_if #(.N(N), .R(R)) bus ();
  datapath_pipe #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  datapath_pipe_if #(.N(4), .R(4)) bus4 ();
  datapath_pipe #(.N(4), .R(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  datapath_pipe_if #(.N(16), .R(16)) bus16 ();
  datapath_pipe #(.N(16), .R(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: each word completes before the next one starts
  logic [N-1:0] m_reg [R];
  logic [3:0]   m_flags;
  logic [3:0]   m_flags_vis;
  logic [N-1:0] m_dout;
  logic [N-1:0] m_aout;
  logic         m_ov;

  function automatic longint to_signed(input longint unsigned x);
    longint unsigned full = longint'(1) << N;
    return (x >= full / 2) ? longint'(x) - longint'(full) : longint'(x);
  endfunction

  // Returns {F, C, V}
  function automatic logic [N+1:0] ref_alu(input logic [3:0] fs, input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned full = longint'(1) << N;
    longint unsigned mask = full - 1;
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint unsigned y = 0;
    longint unsigned r = 0;
    longint sr;
    int cin = 0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic [N-1:0] f;
    if (fs >= 4'd1 && fs <= 4'd6) begin
      case (fs)
        4'd1: cin = 1;
        4'd2: y = ub;
        4'd3: begin y = ub; cin = 1; end
        4'd4: y = ~ub & mask;
        4'd5: begin y = ~ub & mask; cin = 1; end
        default: y = mask;
      endcase
      r  = ua + y + longint'(cin);
      c  = (r >= full);
      sr = to_signed(ua) + to_signed(y) + longint'(cin);
      v  = (sr > longint'(full / 2) - 1) || (sr < -longint'(full / 2));
    end else begin
      case (fs)
        4'd0, 4'd7: r = ua;
        4'd8:  r = ua & ub;
        4'd9:  r = ua | ub;
        4'd10: r = ua ^ ub;
        4'd11: r = ~ua & mask;
        4'd13: begin r = ub / 2; c = ub[0]; end
        4'd14: begin r = (ub * 2) & mask; c = b[N-1]; end
        default: r = ub;
      endcase
    end
    f = N'(r & mask);
    return {f, c, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(R); i++) m_reg[i] = '0;
    m_flags = '0; m_flags_vis = '0; m_dout = '0; m_aout = '0; m_ov = 1'b0;
  endtask

  // Drive one control word on the main instance and advance the model
  task automatic drive(input logic v, input logic [3:0] fs, input int a, input int b, input int d,
                       input logic mb, input logic md, input logic wr,
                       input logic [N-1:0] din, input logic [N-1:0] cin);
    logic [N-1:0] opa, opb, f;
    logic [N+1:0] res;
    bus.ctrl_valid = v;  bus.fs = fs;
    bus.a_sel = AW'(a);  bus.b_sel = AW'(b);  bus.d_sel = AW'(d);
    bus.mb_s = mb;  bus.md_s = md;  bus.wr_en = wr;
    bus.data_in = din;  bus.const_in = cin;
    m_flags_vis = m_flags;
    m_ov = v;
    if (v) begin
      opa = m_reg[a % int'(R)];
      opb = mb ? cin : m_reg[b % int'(R)];
      m_aout = opa;
      m_dout = opb;
      res = ref_alu(fs, opa, opb);
      f = res[N+1:2];
      if (wr) m_reg[d % int'(R)] = md ? din : f;
      if (!md) m_flags = {f == '0, f[N-1], res[1], res[0]};
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a register out through adrs_out without touching flags or the array
  task automatic read_reg(input int r);
    drive(1'b1, 4'd0, r, r, 0, 1'b0, 1'b1, 1'b0, '0, '0);
    tick();
  endtask

  task automatic write_reg(input int r, input logic [N-1:0] val);
    drive(1'b1, 4'd0, 0, 0, r, 1'b0, 1'b1, 1'b1, val, '0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out); end
    n_checks++; if (bus.adrs_out !== '0) begin n_fail++; $display("FAIL reset_adrs_out: got %h expected 0", bus.adrs_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.state_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", bus.state_flags); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd0, 0, 0, 1, 1'b0, 1'b1, 1'b1, 8'h7F, '0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_out_valid: got %b expected 1", bus.out_valid); end
    drive(1'b1, 4'd1, 1, 0, 2, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    n_checks++; if (bus.adrs_out !== 8'h7F) begin n_fail++; $display("FAIL bypass_operand_a: got %h expected 7f", bus.adrs_out); end
    idle();
    tick();
    n_checks++; if (bus.state_flags !== 4'b0101) begin n_fail++; $display("FAIL bypass_flags: got %b expected 0101", bus.state_flags); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_bubble_valid: got %b expected 0", bus.out_valid); end
    read_reg(2);
    n_checks++; if (bus.adrs_out !== 8'h80) begin n_fail++; $display("FAIL bypass_reg2: got %h expected 80", bus.adrs_out); end
  endtask

  task automatic test_subtract();
    write_reg(3, 8'h05);
    drive(1'b1, 4'd5, 3, 0, 3, 1'b1, 1'b0, 1'b1, '0, 8'h05);
    tick();
    n_checks++; if (bus.data_out !== 8'h05) begin n_fail++; $display("FAIL sub_data_out: got %h expected 05", bus.data_out); end
    n_checks++; if (bus.adrs_out !== 8'h05) begin n_fail++; $display("FAIL sub_adrs_out: got %h expected 05", bus.adrs_out); end
    idle();
    tick();
    n_checks++; if (bus.state_flags !== 4'b1010) begin n_fail++; $display("FAIL sub_flags: got %b expected 1010", bus.state_flags); end
    read_reg(3);
    n_checks++; if (bus.adrs_out !== 8'h00) begin n_fail++; $display("FAIL sub_reg3: got %h expected 00", bus.adrs_out); end
  endtask

  task automatic test_shift();
    write_reg(4, 8'h81);
    drive(1'b1, 4'd14, 0, 4, 5, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    drive(1'b1, 4'd13, 0, 4, 6, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    n_checks++; if (bus.state_flags !== 4'b0010) begin n_fail++; $display("FAIL shl_flags: got %b expected 0010", bus.state_flags); end
    drive(1'b1, 4'd8, 4, 4, 7, 1'b0, 1'b0, 1'b1, '0, '0);
    tick();
    n_checks++; if (bus.state_flags !== 4'b0010) begin n_fail++; $display("FAIL shr_flags: got %b expected 0010", bus.state_flags); end
    idle();
    tick();
    n_checks++; if (bus.state_flags !== 4'b0100) begin n_fail++; $display("FAIL and_flags: got %b expected 0100", bus.state_flags); end
    read_reg(5);
    n_checks++; if (bus.adrs_out !== 8'h02) begin n_fail++; $display("FAIL shl_result: got %h expected 02", bus.adrs_out); end
    read_reg(6);
    n_checks++; if (bus.adrs_out !== 8'h40) begin n_fail++; $display("FAIL shr_result: got %h expected 40", bus.adrs_out); end
  endtask

  task automatic test_hold();
    logic [3:0] held;
    drive(1'b1, 4'd2, 4, 5, 4, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_word: got %b expected 1", bus.out_valid); end
    idle();
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_bubble_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.adrs_out !== 8'h81) begin n_fail++; $display("FAIL hold_adrs_out: got %h expected 81", bus.adrs_out); end
    n_checks++; if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL hold_data_out: got %h expected 02", bus.data_out); end
    n_checks++; if (bus.state_flags !== m_flags_vis) begin n_fail++; $display("FAIL hold_flags_nowrite: got %b expected %b", bus.state_flags, m_flags_vis); end
    held = m_flags_vis;
    idle();
    tick();
    n_checks++; if (bus.state_flags !== held) begin n_fail++; $display("FAIL hold_flags_bubble: got %b expected %b", bus.state_flags, held); end
    read_reg(4);
    n_checks++; if (bus.adrs_out !== 8'h81) begin n_fail++; $display("FAIL hold_reg4: got %h expected 81", bus.adrs_out); end
  endtask

  task automatic test_reset_in_ex();
    drive(1'b1, 4'd0, 0, 0, 6, 1'b0, 1'b1, 1'b1, 8'hAA, '0);
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL rst_ex_data_out: got %h expected 0", bus.data_out); end
    n_checks++; if (bus.adrs_out !== '0) begin n_fail++; $display("FAIL rst_ex_adrs_out: got %h expected 0", bus.adrs_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.state_flags !== 4'b0000) begin n_fail++; $display("FAIL rst_ex_flags: got %b expected 0000", bus.state_flags); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    read_reg(6);
    n_checks++; if (bus.adrs_out !== 8'h00) begin n_fail++; $display("FAIL rst_ex_reg6: got %h expected 00", bus.adrs_out); end
    write_reg(6, 8'h3C);
    read_reg(6);
    n_checks++; if (bus.adrs_out !== 8'h3C) begin n_fail++; $display("FAIL rst_ex_resume: got %h expected 3c", bus.adrs_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 8) != 0, 4'($urandom), int'($urandom % R), int'($urandom % R), int'($urandom % R),
            1'($urandom), (($urandom % 4) == 0), (($urandom % 4) != 0), N'($urandom), N'($urandom));
      tick();
      n_checks++; if (bus.out_valid !== m_ov) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid, m_ov); end
      n_checks++; if (bus.adrs_out !== m_aout) begin n_fail++; $display("FAIL rand_adrs_out[%0d]: got %h expected %h", i, bus.adrs_out, m_aout); end
      n_checks++; if (bus.data_out !== m_dout) begin n_fail++; $display("FAIL rand_data_out[%0d]: got %h expected %h", i, bus.data_out, m_dout); end
      n_checks++; if (bus.state_flags !== m_flags_vis) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b expected %b", i, bus.state_flags, m_flags_vis); end
    end
    for (int r = 0; r < int'(R); r++) begin
      read_reg(r);
      n_checks++; if (bus.adrs_out !== m_reg[r]) begin n_fail++; $display("FAIL rand_reg[%0d]: got %h expected %h", r, bus.adrs_out, m_reg[r]); end
    end
  endtask

  // Scaled first scenario on the N=4/R=4 and N=16/R=16 instances
  task automatic test_param_sweep();
    bus4.ctrl_valid = 1'b1; bus4.fs = 4'd0; bus4.d_sel = 2'd1; bus4.md_s = 1'b1; bus4.wr_en = 1'b1; bus4.data_in = 4'h7;
    bus16.ctrl_valid = 1'b1; bus16.fs = 4'd0; bus16.d_sel = 4'd1; bus16.md_s = 1'b1; bus16.wr_en = 1'b1; bus16.data_in = 16'h7FFF;
    tick();
    bus4.fs = 4'd1; bus4.a_sel = 2'd1; bus4.d_sel = 2'd2; bus4.md_s = 1'b0;
    bus16.fs = 4'd1; bus16.a_sel = 4'd1; bus16.d_sel = 4'd2; bus16.md_s = 1'b0;
    tick();
    n_checks++; if (bus4.adrs_out !== 4'h7) begin n_fail++; $display("FAIL sweep4_bypass: got %h expected 7", bus4.adrs_out); end
    n_checks++; if (bus16.adrs_out !== 16'h7FFF) begin n_fail++; $display("FAIL sweep16_bypass: got %h expected 7fff", bus16.adrs_out); end
    bus4.ctrl_valid = 1'b0; bus16.ctrl_valid = 1'b0;
    tick();
    n_checks++; if (bus4.state_flags !== 4'b0101) begin n_fail++; $display("FAIL sweep4_flags: got %b expected 0101", bus4.state_flags); end
    n_checks++; if (bus16.state_flags !== 4'b0101) begin n_fail++; $display("FAIL sweep16_flags: got %b expected 0101", bus16.state_flags); end
    bus4.ctrl_valid = 1'b1; bus4.fs = 4'd0; bus4.a_sel = 2'd2; bus4.md_s = 1'b1; bus4.wr_en = 1'b0;
    bus16.ctrl_valid = 1'b1; bus16.fs = 4'd0; bus16.a_sel = 4'd2; bus16.md_s = 1'b1; bus16.wr_en = 1'b0;
    tick();
    n_checks++; if (bus4.adrs_out !== 4'h8) begin n_fail++; $display("FAIL sweep4_reg2: got %h expected 8", bus4.adrs_out); end
    n_checks++; if (bus16.adrs_out !== 16'h8000) begin n_fail++; $display("FAIL sweep16_reg2: got %h expected 8000", bus16.adrs_out); end
    bus4.ctrl_valid = 1'b0; bus16.ctrl_valid = 1'b0;
  endtask

  initial begin
    bus4.ctrl_valid = 1'b0; bus4.fs = '0; bus4.a_sel = '0; bus4.b_sel = '0; bus4.d_sel = '0;
    bus4.mb_s = 1'b0; bus4.md_s = 1'b0; bus4.wr_en = 1'b0; bus4.data_in = '0; bus4.const_in = '0;
    bus16.ctrl_valid = 1'b0; bus16.fs = '0; bus16.a_sel = '0; bus16.b_sel = '0; bus16.d_sel = '0;
    bus16.mb_s = 1'b0; bus16.md_s = 1'b0; bus16.wr_en = 1'b0; bus16.data_in = '0; bus16.const_in = '0;
    model_reset();
    test_reset();
    test_bypass();
    test_subtract();
    test_shift();
    test_hold();
    test_reset_in_ex();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, two-stage pipelined successor to the 4-bit processing unit datapath. It provides an R-entry, N-bit register file with two read ports and one write port, a 16-function arithmetic/logic/shift unit, operand-B and destination muxes, a registered Z/N/C/V flag register, and a single-stage bypass so back-to-back dependent control words execute without stalls. A control sequencer drives it one control word per cycle, qualified by a valid bit.

## Interface
- N, 8, data width (N ≥ 2)
- R, 8, register count (power of two, R ≥ 2); AW = $clog2(R), derived, not overridable
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ctrl_valid  in  1  control word below is valid this cycle
- fs  in  4  function select
- a_sel, b_sel, d_sel  in  AW each  read-port A, read-port B and write addresses
- mb_s  in  1  0: operand B = reg[b_sel]; 1: operand B = const_in
- md_s  in  1  0: write-back = function-unit result; 1: write-back = data_in
- wr_en  in  1  write-back enable
- data_in  in  N  external data bus
- const_in  in  N  constant operand
- data_out  out  N  registered operand B (after mb mux)
- adrs_out  out  N  registered operand A
- out_valid  out  1  data_out/adrs_out belong to a valid control word
- state_flags  out  4  {Z,N,C,V}, registered

## Operation
- Stage RD (cycle t, ctrl_valid=1): read A and B, apply bypass, apply mb mux, latch operands plus fs/d_sel/md_s/wr_en and the valid bit into the EX register at the edge ending t.
- Stage EX (cycle t+1): compute F, select write-back via md_s, write reg[d_sel] at the edge ending t+1 when wr_en=1, and update flags at the same edge.
- Bypass: if the EX entry is valid with wr_en=1 and its d_sel equals a_sel (or b_sel with mb_s=0), the RD read takes the EX write-back value. This applies to both ports independently.
- Function select, with N-bit adder carry-out as C:
  - 0: A
  - 1: A+1
  - 2: A+B
  - 3: A+B+1
  - 4: A+~B
  - 5: A+~B+1
  - 6: A+all-ones (A−1)
  - 7: A
  - 8: A&B
  - 9: A|B
  - 10: A^B
  - 11: ~A
  - 12: B
  - 13: B>>1 logical, C=B[0]
  - 14: B<<1, C=B[N−1]
  - 15: B
- Flags:
  - Z = (F==0).
  - N = F[N−1].
  - C = carry-out for fs 0–7 (0 for fs 0 and 7), shifted-out bit for fs 13–14, 0 otherwise.
  - V = signed overflow for fs 1–6, 0 otherwise.
- Flags update only for a valid EX entry with md_s=0. If md_s=1, flags hold.
- Bubble (ctrl_valid=0): the EX entry is invalid, so no write, no flag update, out_valid=0 next cycle, and data_out/adrs_out hold their previous values.
- A write and a read of the same register in the same cycle resolve through the bypass, so the new value is seen.
- d_sel may be any register. All registers are general purpose.

## Timing
- Reset (asynchronous, any cycle): all registers = 0, EX entry invalid, data_out = adrs_out = 0, out_valid = 0, state_flags = 0. An in-flight EX write is discarded.
- First valid control word is accepted in the first cycle with rst low.
- data_out, adrs_out, out_valid are valid in cycle t+1 for a word issued in t.
- Write-back is architecturally visible from cycle t+1 (via bypass) and in the array from t+2.
- state_flags reflect the word issued in t from cycle t+2.
- Throughput: one word per cycle, with no stalls.
- Arithmetic wraps modulo 2^N.

## Test plan
- Reset, then issue `md_s=1, data_in=8'h7F, d_sel=1, wr_en=1` followed by `fs=1, a_sel=1, d_sel=2` back-to-back. Required: reg2 = 8'h80, flags {Z,N,C,V} = 0101 at t+2, and the bypass is exercised.
- Set `reg3=8'h05`. Issue `fs=5, a_sel=3, mb_s=1, const_in=8'h05, d_sel=3`. Required: reg3 = 0, flags = 1010, data_out = 8'h05, adrs_out = 8'h05.
- Set `reg4=8'h81`. Issue `fs=14` then `fs=13` on reg4 → reg5. Required: the first gives F=8'h02 with C=1. The second gives F=8'h40 with C=1. Flags for logic ops show C=V=0.
- Issue a word with `wr_en=0`, then a word with `ctrl_valid=0`. Required: register file unchanged, out_valid low for the bubble cycle, and flags held.
- Assert rst during the EX cycle of a `wr_en=1` word. Required: the target register stays 0, all outputs are 0 immediately after rst rises, and normal operation resumes on release.
- Parameter sweep N=4,R=4 and N=16,R=16 using the first scenario, scaled. Required: identical functional results.
